// File: rtl/parity_frame_acc_pkg.sv
// Shared types and helpers for the frame parity accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parity_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Word-counter width; a single-word frame still needs one bit of storage.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_frame_acc_if.sv
// Input word stream and output result stream of the frame parity accumulator.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both streams.
interface parity_frame_acc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_col;
  logic             out_par;

  // Word source / result sink side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_col, out_par
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_col, out_par
  );
endinterface

// File: rtl/parity_frame_acc_reduce.sv
// XOR-reduces a word and folds in the parity mode bit (1 = odd).
// Latency: combinational.
// Backpressure: none.
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic             mode_i,
  output logic             par_o
);

  assign par_o = (^word_i) ^ mode_i;

endmodule

// File: rtl/parity_frame_acc.sv
// Accumulates column parity and frame parity over FRAME_LEN words, checks against expected parity.
// Latency: result valid 1 cycle after the last word is accepted.
// Backpressure: the result is held until out_ready; no words are accepted while a result is held.
module parity_frame_acc
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ERR_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_frame_acc_if.slave bus,
  input  logic              odd_mode,
  input  logic              chk_en,
  input  logic              exp_par,
  input  logic              err_clr,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int             CNT_W   = cnt_w(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   col_acc_q;
  logic               mode_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_col_q;
  logic               out_par_q;
  logic [ERR_W-1:0]   err_cnt_q;

  logic               in_fire;
  logic               out_fire;
  logic               last_wd;
  logic               mode_d;
  logic [WIDTH-1:0]   col_d;
  logic               par_d;
  logic               mismatch;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  assign last_wd  = (cnt_q == CNT_LAST);
  // The first word of a frame supplies the mode directly so single-word frames work.
  assign mode_d   = (cnt_q == '0) ? odd_mode : mode_q;
  assign col_d    = col_acc_q ^ bus.in_data;
  assign mismatch = in_fire & last_wd & chk_en & (exp_par != par_d);

  parity_reduce #(.WIDTH(WIDTH)) u_reduce (
    .word_i (col_d),
    .mode_i (mode_d),
    .par_o  (par_d)
  );

  // Frame FSM: accumulate words, publish the result, hold it until taken; error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      col_acc_q   <= '0;
      mode_q      <= PAR_EVEN;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_par_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (err_clr) begin
        err_cnt_q <= '0;
      end else if (mismatch && (err_cnt_q != ERR_MAX)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end

      case (state_q)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            if (cnt_q == '0) begin
              mode_q <= odd_mode;
            end
            if (last_wd) begin
              out_col_q   <= col_d;
              out_par_q   <= par_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              cnt_q       <= '0;
              col_acc_q   <= '0;
              state_q     <= HOLD;
            end else begin
              col_acc_q <= col_d;
              cnt_q     <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_par   = out_par_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_acc.sv
// Directed bench for parity_frame_acc with a queue-based scoreboard and an independent monitor.
module tb_parity_frame_acc;

  logic       clk;
  logic       rst_n;
  logic       odd_mode;
  logic       chk_en;
  logic       exp_par;
  logic       err_clr;
  logic [1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] col;
    logic       par;
    logic [1:0] err;
  } exp_t;

  exp_t sb[$];

  parity_frame_acc_if #(.WIDTH(8)) bus ();

  parity_frame_acc #(.WIDTH(8), .FRAME_LEN(4), .ERR_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .odd_mode (odd_mode),
    .chk_en   (chk_en),
    .exp_par  (exp_par),
    .err_clr  (err_clr),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [7:0] col, input logic par, input logic [1:0] err);
    exp_t e;
    e.col = col;
    e.par = par;
    e.err = err;
    sb.push_back(e);
  endtask

  // Present one word and hold it until it is accepted (bounded).
  task automatic send(input logic [7:0] d, input logic om, input logic ce,
                      input logic ep, input logic clr);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    odd_mode     = om;
    chk_en       = ce;
    exp_par      = ep;
    err_clr      = clr;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stuck at 0 for word %0h", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk_en       = 1'b0;
    err_clr      = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3, input logic om, input logic ce,
                       input logic ep, input logic clr);
    send(d0, om, 1'b0, 1'b0, 1'b0);
    send(d1, om, 1'b0, 1'b0, 1'b0);
    send(d2, om, 1'b0, 1'b0, 1'b0);
    send(d3, om, ce, ep, clr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({nm, "_out_col"},   32'(bus.out_col),   32'h0);
    chk({nm, "_out_par"},   32'(bus.out_par),   32'h0);
    chk({nm, "_err_cnt"},   32'(err_cnt),       32'h0);
    chk({nm, "_in_ready"},  32'(bus.in_ready),  32'h0);
  endtask

  // Monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: col=%0h par=%0h with empty scoreboard",
                 bus.out_col, bus.out_par);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_col", 32'(bus.out_col), 32'(e.col));
        chk("mon_par", 32'(bus.out_par), 32'(e.par));
        chk("mon_err", 32'(err_cnt),     32'(e.err));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    odd_mode      = 1'b0;
    chk_en        = 1'b0;
    exp_par       = 1'b0;
    err_clr       = 1'b0;
    #1;
    chk_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Case 1: even then odd over 01,02,04,08; result one cycle after last word.
    push(8'h0F, 1'b0, 2'd0);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("latency_out_valid", 32'(bus.out_valid), 32'h1);
    push(8'h0F, 1'b1, 2'd0);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);

    // Case 2: bubbles between words are not counted.
    push(8'hFE, 1'b1, 2'd0);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Case 3: result held under backpressure, words offered meanwhile are refused.
    idle(2);
    bus.out_ready = 1'b0;
    push(8'h0F, 1'b0, 2'd0);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'h1);
      chk("hold_out_col",   32'(bus.out_col),   32'h0F);
      chk("hold_out_par",   32'(bus.out_par),   32'h0);
      chk("hold_in_ready",  32'(bus.in_ready),  32'h0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    idle(2);
    push(8'h0F, 1'b0, 2'd0);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);

    // Case 4: checked mismatches saturate at 3; clear beats a same-cycle increment.
    push(8'h0F, 1'b0, 2'd1);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h0F, 1'b0, 2'd2);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h0F, 1'b0, 2'd3);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h0F, 1'b0, 2'd3);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h0F, 1'b0, 2'd3);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h0F, 1'b0, 2'd0);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1);

    // Case 5: mode is taken from the first word only.
    push(8'h0F, 1'b0, 2'd0);
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h08, 1'b1, 1'b0, 1'b0, 1'b0);

    // Case 6: reset mid-frame and mid-hold discards everything.
    idle(2);
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_frame");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    frame(8'h01, 8'h02, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_hold_valid", 32'(bus.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    push(8'hF0, 1'b0, 2'd0);
    frame(8'h10, 8'h20, 8'h40, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard (bounded).
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("final_out_valid", 32'(bus.out_valid), 32'h0);
    chk("final_in_ready",  32'(bus.in_ready),  32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
